alu_mdu: RTL and testbench
==========================

# alu_mdu

Multi-cycle, width-parametrised successor to the single-cycle ALU in the RISC-V datapath. It keeps the basic ALU opcode map with registered outputs, fixes arithmetic right shift to use B as the shift amount, and adds an iterative multiply/divide unit (RV32M-style MUL, MULHU, DIV, DIVU, REM, REMU). The block sits in the execute stage behind a start/done handshake, so the control unit stalls the PC while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4. `SW = $clog2(WIDTH)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request an operation; sampled only in IDLE.
- `A`, `B` in WIDTH: operands, captured on an accepted `start`.
- `ALUControl` in 4: operation select, captured on an accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when `Result` is valid.
- `Result` out WIDTH: registered result, held until the next `done`.
- `Zero` out 1: registered; high when `Result` == 0.

## Operation
Opcodes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT (signed)
- 1000 SLTU
- 0011 XOR
- 0100 SLL by `B[SW-1:0]`
- 0101 SRL by `B[SW-1:0]`
- 1101 SRA by `B[SW-1:0]`
- 1001 MUL (low WIDTH bits)
- 1010 MULHU (high WIDTH bits, unsigned)
- 1011 DIVU
- 1100 REMU
- 1110 DIV (signed)
- 1111 REM (signed)
- Undefined opcodes complete as basic ops with `Result` = 0.

State machine:
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - `start` with a basic op: compute the result and go to FIN.
  - `start` with a MUL op: load the multiplicand, multiplier and a 2·WIDTH accumulator; go to MUL.
  - `start` with a DIV op: take operand magnitudes for signed ops, record the quotient and remainder signs, load the restoring divider; go to DIV.
- MUL: one shift-add step per cycle for WIDTH cycles; then FIN.
- DIV: one restoring step per cycle for WIDTH cycles; then FIN.
- FIN: apply sign correction, write `Result` and `Zero`, pulse `done`, return to IDLE.

Arithmetic rules:
- Two's complement, wrap-around; no overflow flags.
- Divide by zero:
  - quotient = all ones;
  - remainder = A;
  - still takes the full WIDTH iterations.
- Signed overflow (DIV of the most-negative value by −1): quotient = most-negative value, remainder = 0.
- The REM result takes the sign of A.

Boundary behaviour:
- `start` while `busy`: ignored; operands and ALUControl changes have no effect mid-operation.
- `start` in the same cycle as `done`: ignored; the earliest next accept is the cycle after `done`.
- `reset` mid-operation: aborts immediately; returns to IDLE with reset output values.

## Timing
- Reset values: `busy` = 0, `done` = 0, `Result` = 0, `Zero` = 1, state = IDLE.
- Start accepted at edge N:
  - Basic ops: `done` and `Result` valid after edge N+1 (latency 1); `busy` high for 1 cycle.
  - MUL/DIV ops: `done` and `Result` valid after edge N+WIDTH+1 (latency WIDTH+1, i.e. 33 for WIDTH=32).
- `busy` deasserts in the same cycle that `done` asserts.
- `Result` and `Zero` change only on `done` or `reset`.

## Configuration
- `ALU_MDU_DIV_EN` defined: the divider datapath and DIV state are compiled in as above.
- `ALU_MDU_DIV_EN` undefined:
  - The divider logic is omitted.
  - Opcodes 1011, 1100, 1110 and 1111 complete as basic ops (latency 1) with `Result` = 0.
  - MUL ops are unaffected.

## Test plan
- Reset asserted mid-MUL at cycle 10 → `busy` = 0, `Result` = 0 and `Zero` = 1 immediately; the next `start` ADD 5+7 gives `Result` = 12 one cycle later.
- ADD 0xFFFFFFFF + 1 → `Result` = 0, `Zero` = 1, `done` at N+1; SRA 0x80000000 by B = 4 → `Result` = 0xF8000000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → MUL gives 0x00000001 and MULHU gives 0xFFFFFFFE, each with `done` exactly 33 cycles after `start`.
- DIV −7 / 2 → −3 (0xFFFFFFFD); REM −7 / 2 → −1 (0xFFFFFFFF); DIVU 100 / 0 → 0xFFFFFFFF; REMU 100 / 0 → 100.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; the matching REM → 0 with `Zero` = 1.
- Hold `start` high with changing operands throughout a DIV → exactly one `done`, with the result of the first operands; the next accept occurs the cycle after `done`.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle ALU with iterative shift-add multiplier and restoring divider (divider built only with ALU_MDU_DIV_EN)
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);
  localparam int SW = $clog2(WIDTH);
`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  function automatic logic is_mul(input logic [3:0] op);
    return op == 4'b1001 || op == 4'b1010;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return DIV_EN && (op == 4'b1011 || op == 4'b1100 || op[3:1] == 3'b111);
  endfunction
  state_t state, state_n;
  logic [SW-1:0] cnt;
  logic [3:0] op;
  logic [WIDTH-1:0] a, b, alu_res, mul_res, fin_res;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0] sum;
  logic accept, last;
  assign accept = state == IDLE && start && !done;
  assign last = cnt == SW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
  assign mul_res = op[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next-state: basic ops go straight to FIN, MUL/DIV iterate WIDTH cycles
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !accept ? IDLE : is_mul(ALUControl) ? MUL : is_div(ALUControl) ? DIV : FIN;
      MUL, DIV: state_n = last ? FIN : state;
      default:  state_n = IDLE;
    endcase
  end
  // single-cycle ALU evaluated on the captured operands
  always_comb begin
    alu_res = '0;
    case (op)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: alu_res = a + b;
      4'b0110: alu_res = a - b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      4'b0011: alu_res = a ^ b;
      4'b0100: alu_res = a << b[SW-1:0];
      4'b0101: alu_res = a >> b[SW-1:0];
      4'b1101: alu_res = $signed(a) >>> b[SW-1:0];
      default: alu_res = '0;
    endcase
  end
`ifdef ALU_MDU_DIV_EN
  logic [WIDTH-1:0] rem, quo, div_res;
  logic [WIDTH:0] trial;
  logic q_neg, r_neg, sgn;
  assign sgn = ALUControl[3:1] == 3'b111;
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, b};
  assign div_res = (op == 4'b1100 || op == 4'b1111) ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
  assign fin_res = is_mul(op) ? mul_res : is_div(op) ? div_res : alu_res;
  // restoring divider on magnitudes; a zero divisor naturally yields all-ones quotient and remainder = dividend
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem <= '0;
      quo <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      rem <= '0;
      quo <= (sgn && A[WIDTH-1]) ? -A : A;
      q_neg <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]) && B != '0;
      r_neg <= sgn && A[WIDTH-1];
    end else if (state == DIV) begin
      rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], !trial[WIDTH]};
    end
`else
  assign fin_res = is_mul(op) ? mul_res : alu_res;
`endif
  // operand capture, shift-add multiply steps and result write-back in FIN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      done <= 1'b0;
      Result <= '0;
      Zero <= 1'b1;
    end else begin
      done <= state == FIN;
      if (accept) begin
        cnt <= '0;
        op <= ALUControl;
        a <= A;
        b <= (DIV_EN && ALUControl[3:1] == 3'b111 && B[WIDTH-1]) ? -B : B;
        acc <= {{WIDTH{1'b0}}, B};
      end else if (state == MUL || state == DIV) cnt <= cnt + SW'(1);
      if (state == MUL) acc <= {sum, acc[WIDTH-1:1]};
      if (state == FIN) begin
        Result <= fin_res;
        Zero <= fin_res == '0;
      end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: table-driven check of alu_mdu results/latency plus held-start and mid-op reset sequences
module tb_alu_mdu;
  localparam int W = 32;
`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [3:0] AND = 4'b0000, OR = 4'b0001, ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111,
    SLTU = 4'b1000, XOR = 4'b0011, SLL = 4'b0100, SRL = 4'b0101, SRA = 4'b1101, MUL = 4'b1001,
    MULHU = 4'b1010, DIVU = 4'b1011, REMU = 4'b1100, DIV = 4'b1110, REM = 4'b1111;
  logic clk = 1'b0, reset, start, busy, done, Zero;
  logic [W-1:0] A, B, Result;
  logic [3:0] ALUControl;
  int applied = 0, miscompares = 0;
  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a, b, r;
  } vec_t;
  vec_t tab[$];

  alu_mdu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .ALUControl(ALUControl), .busy(busy), .done(done), .Result(Result), .Zero(Zero));

  always #5 clk = ~clk;

  function automatic bit is_div(input logic [3:0] op);
    return op == DIVU || op == REMU || op == DIV || op == REM;
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op == MUL || op == MULHU || (DIV_EN && is_div(op))) ? W + 1 : 1;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r;
    tab.push_back(v);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    if (done) @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r);
    int lat;
    logic [W-1:0] exp;
    exp = (is_div(op) && !DIV_EN) ? '0 : r;
    wait_idle();
    ALUControl = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " busy"}, {31'b0, busy}, 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 200);
    check({name, " latency"}, lat, exp_lat(op));
    check({name, " result"}, Result, exp);
    check({name, " zero"}, {31'b0, Zero}, {31'b0, exp == '0});
    check({name, " busy at done"}, {31'b0, busy}, 0);
  endtask

  initial begin
    logic [3:0] hop;
    logic [W-1:0] ha, hb, hexp;
    int hlat, ndone, dcyc;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUControl = '0;
    #2;
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset result", Result, 0);
    check("reset zero", {31'b0, Zero}, 1);
    @(negedge clk); reset = 1'b0;

    add(ADD, 32'hFFFFFFFF, 32'h1, 32'h0);
    add(ADD, 32'h5, 32'h7, 32'hC);
    add(SUB, 32'h5, 32'h7, 32'hFFFFFFFE);
    add(AND, 32'hF0F0, 32'hFF00, 32'hF000);
    add(OR, 32'hF0F0, 32'hFF00, 32'hFFF0);
    add(XOR, 32'hF0F0, 32'hFF00, 32'h0FF0);
    add(SLT, 32'hFFFFFFFF, 32'h1, 32'h1);
    add(SLT, 32'h1, 32'hFFFFFFFF, 32'h0);
    add(SLTU, 32'hFFFFFFFF, 32'h1, 32'h0);
    add(SLTU, 32'h1, 32'hFFFFFFFF, 32'h1);
    add(SLL, 32'h1, 32'h3F, 32'h80000000);
    add(SRL, 32'h80000000, 32'h4, 32'h08000000);
    add(SRA, 32'h80000000, 32'h4, 32'hF8000000);
    add(SRA, 32'h40000000, 32'h24, 32'h04000000);
    add(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
    add(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    add(MUL, 32'd12345, 32'd1000, 32'h00BC5EA8);
    add(MULHU, 32'd12345, 32'd1000, 32'h0);
    add(MULHU, 32'h80000000, 32'h4, 32'h2);
    add(DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
    add(REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
    add(DIVU, 32'd100, 32'h0, 32'hFFFFFFFF);
    add(REMU, 32'd100, 32'h0, 32'd100);
    add(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    add(REM, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    add(DIVU, 32'd100, 32'd7, 32'd14);
    add(REMU, 32'd100, 32'd7, 32'd2);
    add(DIV, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    add(REM, 32'h7, 32'hFFFFFFFE, 32'h1);
    add(DIV, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF);
    add(REM, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB);
    for (int i = 0; i < tab.size(); i++)
      run_op($sformatf("vec%0d op%b", i, tab[i].op), tab[i].op, tab[i].a, tab[i].b, tab[i].r);

    if (DIV_EN) begin hop = DIVU; ha = 32'd100; hb = 32'd7; hexp = 32'd14; end
    else begin hop = MUL; ha = 32'd6; hb = 32'd7; hexp = 32'd42; end
    hlat = W + 1;
    wait_idle();
    ALUControl = hop; A = ha; B = hb; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= hlat; c++) begin
      ALUControl = ADD; A = $urandom; B = $urandom;
      @(posedge clk); #1;
      if (done) begin ndone++; dcyc = c; end
    end
    check("hold done count", ndone, 1);
    check("hold done cycle", dcyc, hlat);
    check("hold result", Result, hexp);
    A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    check("hold ignored on done busy", {31'b0, busy}, 0);
    check("hold ignored on done done", {31'b0, done}, 0);
    @(posedge clk); #1;
    check("hold next accept busy", {31'b0, busy}, 1);
    @(posedge clk); #1;
    check("hold next done", {31'b0, done}, 1);
    check("hold next result", Result, 32'd7);
    start = 1'b0;

    wait_idle();
    ALUControl = MUL; A = 32'd3; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midop reset busy", {31'b0, busy}, 0);
    check("midop reset done", {31'b0, done}, 0);
    check("midop reset result", Result, 0);
    check("midop reset zero", {31'b0, Zero}, 1);
    @(negedge clk); reset = 1'b0;
    run_op("post reset add", ADD, 32'd5, 32'd7, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
